// File: rtl/decred_result_collector.sv
// Round-robin readback of NUM_MACROS hash macros over a shared byte bus into a record FIFO.
// Define DECRED_RESULT_STATS_EN to build the saturating RESULT_COUNT push counter.
module decred_result_collector #(
    parameter int         NUM_MACROS   = 4,
    parameter int         RESULT_BYTES = 4,
    parameter logic [5:0] BASE_ADDR    = 6'h20,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [NUM_MACROS-1:0]         DATA_AVAILABLE,
    output logic [NUM_MACROS-1:0]         MACRO_RD_SELECT,
    output logic [5:0]                    HASH_ADDR,
    input  logic [7:0]                    DATA_FROM_HASH,
    output logic [NUM_MACROS-1:0]         RESULT_CLR,
    output logic                          RES_VALID,
    input  logic                          RES_READY,
    output logic [$clog2(NUM_MACROS)-1:0] RES_MACRO,
    output logic [8*RESULT_BYTES-1:0]     RES_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [15:0]                   RESULT_COUNT
);

    localparam int MW = $clog2(NUM_MACROS);
    localparam int DW = 8 * RESULT_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CLEAR, S_HOLD} state_t;

    state_t            state_q;
    logic [MW-1:0]     g_q;
    logic [MW-1:0]     ptr_q;
    logic [BW-1:0]     byte_q;
    logic [NUM_MACROS-1:0] sel_q;
    logic [5:0]        addr_q;
    logic [NUM_MACROS-1:0] clr_q;
    logic [DW-1:0]     shift_q;
    logic [DW-1:0]     shift_d;

    logic [MW-1:0]     wr_q;
    logic [MW+DW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [MW+DW-1:0]  head;

    logic              gnt_hit;
    logic [MW-1:0]     gnt_idx;
    logic [MW-1:0]     cand;
    logic              start;
    logic              capture;
    logic              push;
    logic              pop;

    // First pending macro at or above ptr_q, wrapping; descending scan leaves the nearest.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_MACROS - 1; k >= 0; k--) begin
            cand = MW'((int'(ptr_q) + k) % NUM_MACROS);
            if (DATA_AVAILABLE[cand]) begin
                gnt_hit = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign start   = ENABLE && gnt_hit && (level_q < LW'(FIFO_DEPTH));
    assign capture = (state_q == S_DRAIN) || ((state_q == S_READ) && (byte_q != '0));
    assign push    = (state_q == S_CLEAR);
    assign pop     = RES_VALID && RES_READY;

    // Bytes arrive in order, so shift in at the top; byte 0 ends at the bottom.
    always_comb begin
        shift_d = shift_q >> 8;
        shift_d[DW-1 -: 8] = DATA_FROM_HASH;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            byte_q  <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            clr_q   <= '0;
            shift_q <= '0;
        end else begin
            if (capture) shift_q <= shift_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_READ;
                        g_q     <= gnt_idx;
                        sel_q   <= NUM_MACROS'(1) << gnt_idx;
                        addr_q  <= BASE_ADDR;
                        byte_q  <= '0;
                    end
                end
                S_READ: begin
                    if (byte_q == BW'(RESULT_BYTES - 1)) begin
                        state_q <= S_DRAIN;
                        sel_q   <= '0;
                        addr_q  <= '0;
                    end else begin
                        byte_q  <= byte_q + 1'b1;
                        addr_q  <= BASE_ADDR + 6'(byte_q) + 6'd1;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_CLEAR;
                    clr_q   <= NUM_MACROS'(1) << g_q;
                end
                S_CLEAR: begin
                    state_q <= S_HOLD;
                    clr_q   <= '0;
                    ptr_q   <= (g_q == MW'(NUM_MACROS - 1)) ? '0 : g_q + 1'b1;
                end
                S_HOLD: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_q = g_q;

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {wr_q, shift_q};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Head is gated so an empty FIFO presents zeros rather than stale memory.
    assign head            = mem_q[rd_ptr_q];
    assign RES_VALID       = (level_q != '0);
    assign RES_MACRO       = RES_VALID ? head[MW+DW-1:DW] : '0;
    assign RES_DATA        = RES_VALID ? head[DW-1:0] : '0;
    assign FIFO_LEVEL      = level_q;
    assign MACRO_RD_SELECT = sel_q;
    assign HASH_ADDR       = addr_q;
    assign RESULT_CLR      = clr_q;

`ifdef DECRED_RESULT_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cnt_q <= '0;
        else if (push && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
    assign RESULT_COUNT = cnt_q;
`else
    assign RESULT_COUNT = 16'h0000;
`endif

endmodule
